// File: rtl/handshaking_slave.sv
// Receiving end of a valid/ready link: FIFO buffering, in-order
// re-presentation downstream, and a sticky upstream protocol monitor.
module handshaking_slave #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_WIDTH-1:0]    beat_count,
  output logic                    protocol_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } chk_state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           level_q, level_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  not_full;
  logic                  push, pop;

  chk_state_e            state_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  err_q;

  // Internal logic uses not_full; rst only gates the visible ready.
  assign not_full  = (level_q != FULL);
  assign ready_out = rst & not_full;
  assign valid_out = (level_q != '0);
  assign push      = valid_in & not_full;
  assign pop       = valid_out & ready_in;
  assign data_out  = valid_out ? mem_q[rd_ptr_q] : '0;

  assign level        = level_q;
  assign beat_count   = cnt_q;
  assign protocol_err = err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      cnt_d    = cnt_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // A stalled beat must stay valid with stable data until accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (valid_in && !not_full) begin
            state_q <= S_WAIT;
            hold_q  <= data_in;
          end
        end
        S_WAIT: begin
          if (!valid_in || (data_in != hold_q)) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (not_full) begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshaking_slave.sv
// Randomized and directed bench for handshaking_slave against a
// queue-based reference model.
module tb_handshaking_slave;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          ready_out;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          ready_in = 1'b0;
  logic [2:0]    level;
  logic [CW-1:0] beat_count;
  logic          protocol_err;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] q[$];
  int unsigned   m_bc = 0;
  bit            m_err = 0;
  bit            m_pend = 0;
  logic [DW-1:0] m_pdat = '0;

  handshaking_slave #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .data_out(data_out),
    .valid_out(valid_out),
    .ready_in(ready_in),
    .level(level),
    .beat_count(beat_count),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_bc   = 0;
    m_err  = 0;
    m_pend = 0;
  endtask

  task automatic check_all();
    chk("ready_out", ready_out, (rst && q.size() < DEPTH));
    chk("valid_out", valid_out, q.size() > 0);
    chk("data_out", data_out, q.size() > 0 ? q[0] : 8'h00);
    chk("level", level, q.size());
    chk("beat_count", beat_count, m_bc % 65536);
    chk("protocol_err", protocol_err, m_err);
  endtask

  // Drive one cycle of inputs, predict the edge, then check outputs.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit r);
    bit rdy, acc, pp;
    valid_in = v;
    data_in  = d;
    ready_in = r;
    if (rst) begin
      rdy = q.size() < DEPTH;
      acc = v && rdy;
      pp  = (q.size() > 0) && r;
      if (m_pend) begin
        if (!v || d != m_pdat) begin
          m_err  = 1;
          m_pend = 0;
        end else if (acc) begin
          m_pend = 0;
        end
      end else if (v && !rdy) begin
        m_pend = 1;
        m_pdat = d;
      end
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back(d);
        m_bc++;
      end
    end else begin
      model_clear();
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_clear();
    check_all();
    step(1, 8'h96, 0);
    step(1, 8'h96, 0);
    rst = 1'b1;
    valid_in = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    bit            v, r, held;
    logic [DW-1:0] d;

    // reset with upstream valid asserted
    valid_in = 1'b1;
    data_in  = 8'h96;
    @(negedge clk);
    do_reset();

    // single beat
    step(1, 8'h96, 1);
    chk("t2_data", data_out, 8'h96);
    step(0, 8'h00, 1);
    chk("t2_level", level, 0);
    chk("t2_bc", beat_count, 1);

    // fill to full, then drain in order
    step(1, 8'h69, 0);
    step(1, 8'h00, 0);
    step(1, 8'hFF, 0);
    step(1, 8'h11, 0);
    chk("t3_full_rdy", ready_out, 0);
    chk("t3_full_lvl", level, 4);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1);

    // streaming from a clean counter
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(i), 1);
      chk("t4_lvl", level <= 1, 1);
    end
    chk("t4_bc", beat_count, 20);
    step(0, 8'h00, 1);

    // data change while stalled
    for (int i = 0; i < 4; i++) step(1, 8'(8'h30 + i), 0);
    step(1, 8'hA5, 0);
    chk("t5_pre", protocol_err, 0);
    step(1, 8'h5A, 0);
    chk("t5_err", protocol_err, 1);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1);
    chk("t5_sticky", protocol_err, 1);

    // async reset mid-stream
    for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i), 0);
    chk("t6_lvl3", level, 3);
    #2;
    rst = 1'b0;
    #1;
    model_clear();
    chk("t6_async_lvl", level, 0);
    chk("t6_async_vld", valid_out, 0);
    chk("t6_async_bc", beat_count, 0);
    chk("t6_async_err", protocol_err, 0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 8'h77, 1);
    chk("t6_resume", data_out, 8'h77);

    // randomized traffic from a compliant master, occasional resets
    held = 0;
    d = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!held) begin
        v = ($urandom_range(0, 3) != 0);
        d = 8'($urandom);
      end else begin
        v = 1;
      end
      r = ($urandom_range(0, 2) != 0);
      held = v && (q.size() >= DEPTH);
      step(v, d, r);
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        held = 0;
      end
    end

    // randomized traffic that may break the protocol
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 1) == 1, 8'($urandom_range(0, 3)),
           $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
